data_bus_arbiter: RTL and testbench

//  Shares the single data memory bus (example_data_memory_bus port set) between two

---
 rtl/data_bus_pkg.sv | 33 +++
 rtl/bus_return_tracker.sv | 39 +++
 rtl/data_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared types for the data memory bus arbiter: master identifiers, the default
// request bundle layout and the supported read-latency bound.
package data_bus_pkg;

  localparam int BUS_ADDR_WIDTH   = 32;
  localparam int BUS_DATA_WIDTH   = 32;
  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  // Request bundle for the default bus geometry.
  typedef struct packed {
    logic                        write;
    logic [BUS_ADDR_WIDTH-1:0]   address;
    logic [BUS_DATA_WIDTH-1:0]   write_data;
    logic [BUS_DATA_WIDTH/8-1:0] byte_enable;
  } bus_req_t;

  // The master that loses to, or wins against, the given one on a conflict.
  function automatic master_id_t other_master(input master_id_t id);
    master_id_t res;
    if (id == M0) begin
      res = M1;
    end else begin
      res = M0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_return_tracker.sv
// Tracks accepted reads through the memory latency: a {valid, id} shift pipe whose
// last stage names the master that owns the data currently on bus_read_data.
module bus_return_tracker
  import data_bus_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_valid,
  input  master_id_t push_id,
  output logic       ret_valid,
  output master_id_t ret_id
);

  logic [LATENCY-1:0] valid_r;
  master_id_t         id_r [LATENCY];

  // Shift the read tags one stage per cycle; reset drops every read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        id_r[i] <= M0;
      end
    end else begin
      valid_r[0] <= push_valid;
      id_r[0]    <= push_id;
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        id_r[i]    <= id_r[i-1];
      end
    end
  end

  assign ret_valid = valid_r[LATENCY-1];
  assign ret_id    = id_r[LATENCY-1];

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the single data memory bus: M0 is the core load/store
// port, M1 the AES DMA port. Grants are per cycle, the winner's request drives the
// bus combinationally, and read data is routed back to the issuing master.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic                    m0_write,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [DATA_WIDTH/8-1:0] m0_byte_enable,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  input  logic                    m1_req,
  input  logic                    m1_write,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [DATA_WIDTH/8-1:0] m1_byte_enable,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  output logic [ADDR_WIDTH-1:0]   bus_address,
  output logic [DATA_WIDTH-1:0]   bus_write_data,
  output logic [DATA_WIDTH/8-1:0] bus_byte_enable,
  output logic                    bus_read_enable,
  output logic                    bus_write_enable,
  input  logic [DATA_WIDTH-1:0]   bus_read_data
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [BE_WIDTH-1:0]   byte_enable;
  } req_t;

  req_t       req0_s;
  req_t       req1_s;
  req_t       sel_req_s;
  logic       gnt0_s;
  logic       gnt1_s;
  master_id_t last_grant_r;
  logic       push_valid_s;
  master_id_t push_id_s;
  logic       ret_valid_s;
  master_id_t ret_id_s;

  assign req0_s = {m0_write, m0_address, m0_write_data, m0_byte_enable};
  assign req1_s = {m1_write, m1_address, m1_write_data, m1_byte_enable};

  // Pick at most one winner; on a conflict either M0 is fixed winner or the
  // master that did not win last time goes next, so nobody waits more than a cycle.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (m0_req && m1_req) begin
      if (FIXED_PRIORITY != 0) begin
        gnt0_s = 1'b1;
      end else if (other_master(last_grant_r) == M0) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (m0_req) begin
      gnt0_s = 1'b1;
    end else if (m1_req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Remember the most recent winner; idle cycles leave it untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= M1;
    end else if (gnt0_s) begin
      last_grant_r <= M0;
    end else if (gnt1_s) begin
      last_grant_r <= M1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Steer the winner's request onto the bus; an idle bus is driven all-zero.
  always_comb begin
    sel_req_s = '0;
    if (gnt0_s) begin
      sel_req_s = req0_s;
    end else if (gnt1_s) begin
      sel_req_s = req1_s;
    end else begin
      sel_req_s = '0;
    end
  end

  assign bus_address      = sel_req_s.address;
  assign bus_write_data   = sel_req_s.write_data;
  assign bus_byte_enable  = sel_req_s.byte_enable;
  assign bus_read_enable  = (gnt0_s | gnt1_s) & ~sel_req_s.write;
  assign bus_write_enable = (gnt0_s | gnt1_s) & sel_req_s.write;

  assign m0_gnt = gnt0_s;
  assign m1_gnt = gnt1_s;

  assign push_valid_s = bus_read_enable;
  assign push_id_s    = gnt1_s ? M1 : M0;

  bus_return_tracker #(
    .LATENCY (READ_LATENCY)
  ) u_tracker (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid_s),
    .push_id    (push_id_s),
    .ret_valid  (ret_valid_s),
    .ret_id     (ret_id_s)
  );

  // Route returning data to its owner; the other master sees zero data.
  always_comb begin
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_read_data = '0;
    m1_read_data = '0;
    if (ret_valid_s && (ret_id_s == M0)) begin
      m0_rvalid    = 1'b1;
      m0_read_data = bus_read_data;
    end else if (ret_valid_s && (ret_id_s == M1)) begin
      m1_rvalid    = 1'b1;
      m1_read_data = bus_read_data;
    end else begin
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: four instances (LAT1 round-robin, LAT1 fixed
// priority, LAT3 round-robin, LAT2 round-robin) share the same master stimulus;
// one instance at a time is observed and its read returns are scoreboarded.
module tb_data_bus_arbiter;
  import data_bus_pkg::*;

  localparam int NDUT = 4;

  typedef struct {
    int          master;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;

  logic [NDUT-1:0] m0_gnt_w, m1_gnt_w, m0_rvalid_w, m1_rvalid_w, bus_re_w, bus_we_w;
  logic [31:0]     m0_rdata_w [NDUT];
  logic [31:0]     m1_rdata_w [NDUT];
  logic [31:0]     bus_addr_w [NDUT];
  logic [31:0]     bus_wdata_w [NDUT];
  logic [31:0]     bus_rdata_w [NDUT];
  logic [3:0]      bus_be_w [NDUT];

  int   cyc = 0;
  int   sel = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    if (i == 32'h40) w = 32'hDEADBEEF;
    else             w = 32'hA5A50000 ^ (i * 32'h00010101);
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    return init_word(int'(addr[9:2]));
  endfunction

  function automatic int lat_of(input int d);
    int l;
    if (d == 2)      l = 3;
    else if (d == 3) l = 2;
    else             l = 1;
    return l;
  endfunction

  genvar k;
  generate
    for (k = 0; k < NDUT; k++) begin : g_dut
      localparam int LAT = (k == 2) ? 3 : ((k == 3) ? 2 : 1);
      localparam int FP  = (k == 1) ? 1 : 0;
      logic [31:0] mem [0:255];
      logic [31:0] rd_pipe [0:3];

      data_bus_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(LAT), .FIXED_PRIORITY(FP)
      ) u_dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address),
        .m0_write_data(m0_write_data), .m0_byte_enable(m0_byte_enable),
        .m0_gnt(m0_gnt_w[k]), .m0_rvalid(m0_rvalid_w[k]), .m0_read_data(m0_rdata_w[k]),
        .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address),
        .m1_write_data(m1_write_data), .m1_byte_enable(m1_byte_enable),
        .m1_gnt(m1_gnt_w[k]), .m1_rvalid(m1_rvalid_w[k]), .m1_read_data(m1_rdata_w[k]),
        .bus_address(bus_addr_w[k]), .bus_write_data(bus_wdata_w[k]),
        .bus_byte_enable(bus_be_w[k]), .bus_read_enable(bus_re_w[k]),
        .bus_write_enable(bus_we_w[k]), .bus_read_data(bus_rdata_w[k])
      );

      initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        for (int i = 0; i < 4; i++) rd_pipe[i] = 32'h0;
      end

      // Memory model: byte-lane writes, reads returned LAT cycles after enable.
      always @(posedge clock) begin
        if (bus_we_w[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (bus_be_w[k][b]) mem[bus_addr_w[k][9:2]][8*b +: 8] <= bus_wdata_w[k][8*b +: 8];
          end
        end
        rd_pipe[0] <= bus_re_w[k] ? mem[bus_addr_w[k][9:2]] : 32'h0;
        for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
      end

      assign bus_rdata_w[k] = rd_pipe[LAT-1];
    end
  endgenerate

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d, dut %0d)", tag, obs, exp, cyc, sel);
    end
  endtask

  // Scoreboard: compare every return of the observed instance against the queue.
  always @(negedge clock) begin
    exp_t        e;
    logic        rv;
    logic [31:0] rd;
    if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      check_value("rv_missing", 64'(cyc), 64'(sb_q[0].due));
      void'(sb_q.pop_front());
    end
    for (int m = 0; m < 2; m++) begin
      rv = (m == 0) ? m0_rvalid_w[sel] : m1_rvalid_w[sel];
      rd = (m == 0) ? m0_rdata_w[sel]  : m1_rdata_w[sel];
      if (rv) begin
        if (sb_q.size() == 0) begin
          check_value("rv_unexpected", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check_value("rv_master", 64'(m), 64'(e.master));
          check_value("rv_data", 64'(rd), 64'(e.data));
          check_value("rv_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        check_value("rdata_idle", 64'(rd), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    if (m == 0) begin
      m0_req = req; m0_write = wr; m0_address = addr; m0_write_data = wd; m0_byte_enable = be;
    end else begin
      m1_req = req; m1_write = wr; m1_address = addr; m1_write_data = wd; m1_byte_enable = be;
    end
  endtask

  task automatic idle_both();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic push_exp(input int m, input logic [31:0] data);
    exp_t e;
    e.master = m;
    e.data   = data;
    e.due    = cyc + lat_of(sel);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    idle_both();
    repeat (6) step();
    check_value("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    idle_both();

    // Reset held with both masters requesting: nothing granted, bus quiet.
    sel = 0;
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clock);
      check_value("rst_m0_gnt", 64'(m0_gnt_w[0]), 64'd0);
      check_value("rst_m1_gnt", 64'(m1_gnt_w[0]), 64'd0);
      check_value("rst_bus_re", 64'(bus_re_w[0]), 64'd0);
      check_value("rst_bus_addr", 64'(bus_addr_w[0]), 64'd0);
      check_value("rst_bus_be", 64'(bus_be_w[0]), 64'd0);
    end
    step();
    reset = 1'b0;
    push_exp(0, 32'hDEADBEEF);
    @(negedge clock);
    check_value("post_rst_m0_gnt", 64'(m0_gnt_w[0]), 64'd1);
    check_value("post_rst_m1_gnt", 64'(m1_gnt_w[0]), 64'd0);
    step();
    drain();

    // Single M0 read, latency 1.
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    push_exp(0, 32'hDEADBEEF);
    @(negedge clock);
    check_value("rd_m0_gnt", 64'(m0_gnt_w[0]), 64'd1);
    check_value("rd_m1_gnt", 64'(m1_gnt_w[0]), 64'd0);
    check_value("rd_bus_re", 64'(bus_re_w[0]), 64'd1);
    check_value("rd_bus_we", 64'(bus_we_w[0]), 64'd0);
    check_value("rd_bus_addr", 64'(bus_addr_w[0]), 64'h100);
    step();
    idle_both();
    @(negedge clock);
    check_value("rd_m0_rvalid", 64'(m0_rvalid_w[0]), 64'd1);
    check_value("rd_m1_rvalid", 64'(m1_rvalid_w[0]), 64'd0);
    drain();

    // Continuous conflict: round-robin alternates, fixed priority keeps M0.
    for (int d = 0; d < 2; d++) begin
      sel = d;
      do_reset();
      for (int i = 0; i < 6; i++) begin
        int em;
        drive(0, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 32'h108, 32'h0, 4'hF);
        em = (d == 1) ? 0 : (i % 2);
        push_exp(em, exp_word((em == 0) ? 32'h104 : 32'h108));
        @(negedge clock);
        check_value("cf_m0_gnt", 64'(m0_gnt_w[d]), 64'(em == 0));
        check_value("cf_m1_gnt", 64'(m1_gnt_w[d]), 64'(em == 1));
        step();
      end
      drain();
    end

    // M1 partial write, then M0 reads the merged word back.
    sel = 0;
    do_reset();
    drive(1, 1'b1, 1'b1, 32'h200, 32'h01234567, 4'b0011);
    @(negedge clock);
    check_value("wr_m1_gnt", 64'(m1_gnt_w[0]), 64'd1);
    check_value("wr_m0_gnt", 64'(m0_gnt_w[0]), 64'd0);
    check_value("wr_bus_we", 64'(bus_we_w[0]), 64'd1);
    check_value("wr_bus_re", 64'(bus_re_w[0]), 64'd0);
    check_value("wr_bus_be", 64'(bus_be_w[0]), 64'b0011);
    check_value("wr_bus_wdata", 64'(bus_wdata_w[0]), 64'h01234567);
    check_value("wr_bus_addr", 64'(bus_addr_w[0]), 64'h200);
    step();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    w = exp_word(32'h200);
    push_exp(0, {w[31:16], 16'h4567});
    step();
    drain();

    // Latency 3, alternating single-master reads back to back.
    sel = 2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      int          m;
      logic [31:0] a;
      m = i % 2;
      a = 32'h110 + 32'(4 * i);
      idle_both();
      drive(m, 1'b1, 1'b0, a, 32'h0, 4'hF);
      push_exp(m, exp_word(a));
      @(negedge clock);
      check_value("l3_gnt", 64'((m == 0) ? m0_gnt_w[2] : m1_gnt_w[2]), 64'd1);
      step();
    end
    drain();

    // Latency 2: reset one cycle after an M1 read grant discards the return.
    sel = 3;
    do_reset();
    drive(1, 1'b1, 1'b0, 32'h120, 32'h0, 4'hF);
    @(negedge clock);
    check_value("rr_m1_gnt", 64'(m1_gnt_w[3]), 64'd1);
    step();
    idle_both();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_value("rr_no_m1_rvalid", 64'(m1_rvalid_w[3]), 64'd0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
